mux8_scan_sequencer: RTL
========================

// Module: mux8_scan_sequencer
// PURPOSE
//  Upstream driver for the 8:1 mux stage (8-bit data D, 3-bit select S, active-low enable EN, output Y).
//  Accepts one 8-bit word per valid/ready handshake, holds it on mux_d and steps mux_s through channels 0..7.
//  Holds mux_en_n low only while a frame is scanning, so the mux output Y is Z when the sequencer is idle.
//  Pulses bit_strobe when the downstream capture logic samples Y. Result: a parallel-to-serial frame, LSB first.
// PARAMETERS
//  DWELL  1  clock cycles each channel is held selected; legal range >=1 (DWELL=0 is illegal, flag with $error)
//  GAP    0  idle cycles after a frame, with mux disabled, before in_ready reasserts; legal range >=0
// PORTS
//  clk         in   1  clock; all state updates on rising edge
//  rst         in   1  asynchronous, active-high reset
//  in_data     in   8  word to be scanned
//  in_valid    in   1  in_data valid
//  in_ready    out  1  sequencer can accept a word; combinational: 1 iff state==IDLE
//  mux_d       out  8  registered copy of the accepted word; drives mux D
//  mux_s       out  3  channel select; drives mux S
//  mux_en_n    out  1  mux enable, active-low; drives mux EN (1 = mux output Y is Z)
//  bit_strobe  out  1  one-cycle pulse; Y is valid and equals mux_d[mux_s]
//  frame_last  out  1  asserted together with the bit_strobe of channel 7
//  busy        out  1  1 in SCAN and GAP states
// BEHAVIOUR
//  Reset values (async on rst=1, immediate): state=IDLE, mux_d=8'h00, mux_s=3'd0, mux_en_n=1,
//   bit_strobe=0, frame_last=0, busy=0, dwell/gap counters=0. in_ready=1 once state is IDLE.
//  Counters: dwell counter width $clog2(DWELL+1); gap counter width $clog2(GAP+1) (min 1 bit).
//  FSM states: IDLE, SCAN, GAP.
//  IDLE -> SCAN: when in_valid&in_ready at edge T.
//   - At T+1: mux_d=in_data, mux_s=0, mux_en_n=0, dwell counter=0.
//  SCAN: the dwell counter increments each cycle.
//   - Last dwell cycle of a channel (cnt==DWELL-1): bit_strobe=1 (registered, coincident with that cycle).
//   - At the following edge the counter resets to 0.
//   - If mux_s<7: mux_s increments.
//   - If mux_s==7: frame_last=1 in the same cycle as that strobe.
//  End of frame (edge after the channel-7 strobe):
//   - GAP==0: go to IDLE; mux_en_n=1, mux_s=0.
//   - GAP>0: go to GAP; mux_en_n=1, mux_s=0.
//  GAP -> IDLE: after exactly GAP cycles in GAP. mux_d holds the last word until the next accept.
//  Timing (handshake at edge T):
//   - First strobe in cycle T+DWELL.
//   - Channel-7 strobe in cycle T+8*DWELL.
//   - in_ready=1 again in cycle T+8*DWELL+1+GAP.
//   - Throughput: one word per 8*DWELL+1+GAP cycles. Frames never overlap.
//  in_valid while busy: ignored. mux_d is not disturbed. The word is accepted on the first IDLE cycle if still valid.
//  in_valid with no handshake completed: no state change. in_data is don't-care when in_valid=0.
//  mux_s changes only on a channel boundary, never mid-dwell.
//  bit_strobe is never asserted while mux_en_n=1.
//  rst mid-frame: the frame is dropped with no further strobes. mux_en_n=1 immediately (async), so Y goes Z.
//   After rst deasserts, the first edge with in_valid accepts a new word.
//  All outputs are registered except in_ready.
// TESTING
//  1. rst=1 at any time -> same cycle: mux_en_n=1, mux_s=0, mux_d=0, bit_strobe=0, busy=0. After release, in_ready=1.
//  2. DWELL=1, GAP=0, accept 8'hA5 at T:
//     -> mux_s=0..7 over cycles T+1..T+8, strobe every cycle.
//     -> Sampled Y=1,0,1,0,0,1,0,1. frame_last only at T+8. in_ready=1 at T+9.
//  3. DWELL=3, accept 8'h3C -> each mux_s held 3 cycles, strobe on the 3rd; 8 strobes over T+1..T+24; bits 0,0,1,1,1,1,0,0.
//  4. Hold in_valid=1 during a scan with in_data=8'hFF after accepting 8'h00:
//     -> mux_d stays 8'h00 for the whole frame. 8'hFF is accepted in the next IDLE cycle; back-to-back frames with 1 idle cycle.
//  5. Assert rst during channel 4 of a frame:
//     -> no strobes for channels 4..7, mux_en_n=1 at once.
//     -> After release, 8'h81 is accepted and scanned correctly from channel 0.
//  6. GAP=2, DWELL=1:
//     -> mux_en_n=1 and busy=1 for 2 cycles after the channel-7 strobe; in_ready reasserts at T+11.

Source files
------------

// File: rtl/mux8_scan_sequencer.sv
// ---------------------------------------------------------------------------
// mux8_scan_sequencer
//   Upstream driver for an 8:1 mux stage. Accepts one 8-bit word per
//   valid/ready handshake, holds it on o_mux_d and steps o_mux_s through
//   channels 0..7 (LSB first), each held for DWELL cycles. The mux is enabled
//   (o_mux_en_n low) only while a frame is scanning. After a frame the block
//   idles GAP cycles, with the mux disabled, before accepting the next word.
//
// Parameters
//   DWELL  cycles each channel stays selected (>= 1)
//   GAP    idle cycles after a frame before o_in_ready reasserts (>= 0)
//
// Ports
//   i_clk          clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_in_data      word to be scanned
//   i_in_valid     i_in_data valid
//   o_in_ready     high iff the FSM is IDLE (combinational)
//   o_mux_d        registered copy of the accepted word (mux D)
//   o_mux_s        channel select (mux S)
//   o_mux_en_n     active-low mux enable (mux EN)
//   o_bit_strobe   one-cycle pulse: mux output equals o_mux_d[o_mux_s]
//   o_frame_last   coincides with the channel-7 strobe
//   o_busy         high in SCAN and GAP
// ---------------------------------------------------------------------------
module mux8_scan_sequencer #(
  parameter int DWELL = 1,
  parameter int GAP   = 0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_in_data,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  output logic [7:0] o_mux_d,
  output logic [2:0] o_mux_s,
  output logic       o_mux_en_n,
  output logic       o_bit_strobe,
  output logic       o_frame_last,
  output logic       o_busy
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL + 1) : 1;
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'((DWELL > 0) ? (DWELL - 1) : 0);
  localparam logic [GW-1:0] GAP_LAST   = GW'((GAP > 0) ? (GAP - 1) : 0);

  if (DWELL < 1) begin : g_bad_dwell
    $error("mux8_scan_sequencer: DWELL must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [DW-1:0]   r_dwell_cnt;
  logic [DW-1:0]   w_dwell_nxt;
  logic [GW-1:0]   r_gap_cnt;
  logic [GW-1:0]   w_gap_nxt;
  logic [7:0]      r_mux_d;
  logic [7:0]      w_mux_d_nxt;
  logic [2:0]      r_mux_s;
  logic [2:0]      w_mux_s_nxt;
  logic            r_mux_en_n;
  logic            r_bit_strobe;
  logic            r_frame_last;
  logic            r_busy;
  logic            w_strobe_nxt;
  logic            w_last_nxt;
  logic            w_chan_end;

  // Last dwell cycle of the currently selected channel.
  assign w_chan_end = (r_dwell_cnt == DWELL_LAST);

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_in_valid) begin
          w_state_nxt = ST_SCAN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (w_chan_end && (r_mux_s == 3'd7)) begin
          w_state_nxt = (GAP == 0) ? ST_IDLE : ST_GAP;
        end else begin
          w_state_nxt = ST_SCAN;
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_GAP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output/datapath next values; strobe and enable are derived from the
  // next state so the registered versions line up with the cycle they describe.
  always_comb begin
    w_mux_d_nxt = r_mux_d;
    w_mux_s_nxt = r_mux_s;
    w_dwell_nxt = r_dwell_cnt;
    w_gap_nxt   = r_gap_cnt;
    case (r_state)
      ST_IDLE: begin
        if (i_in_valid) begin
          w_mux_d_nxt = i_in_data;
          w_mux_s_nxt = 3'd0;
          w_dwell_nxt = '0;
        end else begin
          w_mux_s_nxt = 3'd0;
        end
      end
      ST_SCAN: begin
        if (w_chan_end) begin
          w_dwell_nxt = '0;
          // Wrap to channel 0 at end of frame so the idle mux_s is 0.
          w_mux_s_nxt = (r_mux_s == 3'd7) ? 3'd0 : (r_mux_s + 3'd1);
        end else begin
          w_dwell_nxt = r_dwell_cnt + DW'(1);
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_gap_nxt = '0;
        end else begin
          w_gap_nxt = r_gap_cnt + GW'(1);
        end
      end
      default: begin
        w_mux_s_nxt = 3'd0;
        w_dwell_nxt = '0;
        w_gap_nxt   = '0;
      end
    endcase
    w_strobe_nxt = (w_state_nxt == ST_SCAN) && (w_dwell_nxt == DWELL_LAST);
    w_last_nxt   = w_strobe_nxt && (w_mux_s_nxt == 3'd7);
  end

  // Registered outputs and counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mux_d      <= 8'h00;
      r_mux_s      <= 3'd0;
      r_mux_en_n   <= 1'b1;
      r_bit_strobe <= 1'b0;
      r_frame_last <= 1'b0;
      r_busy       <= 1'b0;
      r_dwell_cnt  <= '0;
      r_gap_cnt    <= '0;
    end else begin
      r_mux_d      <= w_mux_d_nxt;
      r_mux_s      <= w_mux_s_nxt;
      r_mux_en_n   <= (w_state_nxt != ST_SCAN);
      r_bit_strobe <= w_strobe_nxt;
      r_frame_last <= w_last_nxt;
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_dwell_cnt  <= w_dwell_nxt;
      r_gap_cnt    <= w_gap_nxt;
    end
  end

  assign o_in_ready   = (r_state == ST_IDLE);
  assign o_mux_d      = r_mux_d;
  assign o_mux_s      = r_mux_s;
  assign o_mux_en_n   = r_mux_en_n;
  assign o_bit_strobe = r_bit_strobe;
  assign o_frame_last = r_frame_last;
  assign o_busy       = r_busy;

endmodule
